ras_verify: RTL and testbench

- Checks return-address-stack predictions made at fetch against JR targets resolved in execute.
- Each IF-stage RAS prediction is queued in an in-order pending FIFO. Each EX-stage JR resolution pops the FIFO head and compares it with the actual target.
- On mismatch, issues a registered redirect PC and runs a fixed-length flush sequence.
- Sits between the RAS outputs (hit/alt_PC) and the fetch redirect mux.

---
 rtl/ras_pkg.sv | 10 +
 rtl/ras_pend_fifo.sv | 45 ++++
 rtl/ras_verify.sv | 83 ++++++++
 tb/tb_ras_verify.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// ras_pkg: shared address width, pending-entry layout and flush FSM states for ras_verify
package ras_pkg;
  localparam int ADDR_W_DEFAULT = 32;
  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] pc;
    logic                      hit;
    logic [ADDR_W_DEFAULT-1:0] target;
  } ras_entry_t;
  typedef enum logic {IDLE, FLUSH} ras_state_t;
endpackage

// File: rtl/ras_pend_fifo.sv
// ras_pend_fifo: in-order pending-prediction FIFO with simultaneous push/pop and synchronous clear
module ras_pend_fifo import ras_pkg::*; #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = ras_entry_t
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 din,
  output entry_t                 dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  entry_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];
  // pointers wrap naturally at DEPTH; clear takes priority over push and pop
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + PW'(do_push);
      rp    <= rp + PW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // entry storage needs no reset: only slots covered by count are ever read as valid
  always_ff @(posedge CLK)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ras_verify.sv
// ras_verify: judges fetch-time RAS predictions against EX JR targets; RAS_VERIFY_STATS_EN adds counters
module ras_verify import ras_pkg::*; #(
  parameter int DEPTH        = 4,
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   pred_valid,
  input  logic                   pred_hit,
  input  logic [ADDR_W-1:0]      pred_pc,
  input  logic [ADDR_W-1:0]      pred_target,
  input  logic                   res_valid,
  input  logic [ADDR_W-1:0]      res_pc,
  input  logic [ADDR_W-1:0]      res_target,
  output logic                   mispredict,
  output logic [ADDR_W-1:0]      redirect_PC,
  output logic                   flush,
  output logic                   pend_full,
`ifdef RAS_VERIFY_STATS_EN
  output logic [31:0]            stat_correct,
  output logic [31:0]            stat_mispred,
`endif
  output logic [$clog2(DEPTH):0] pend_count
);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  ras_state_t state, state_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  ras_entry_t head, wr;
  logic empty, idle, judge, ok, bad;
  assign idle  = state == IDLE;
  assign judge = res_valid && idle;
  assign ok    = !empty && head.pc == res_pc && head.hit && head.target == res_target;
  assign bad   = judge && !ok;
  assign flush = !idle;
  assign wr    = '{pc: pred_pc, hit: pred_hit, target: pred_target};
  ras_pend_fifo #(.DEPTH(DEPTH), .entry_t(ras_entry_t)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (bad),
    .push  (pred_valid && idle),
    .pop   (judge),
    .din   (wr),
    .dout  (head),
    .full  (pend_full),
    .empty (empty),
    .count (pend_count)
  );
  // flush sequencer state and down-counter
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
    end
  // enter FLUSH on a bad resolve, leave after the counter has covered FLUSH_CYCLES cycles
  always_comb begin
    state_nx = bad ? FLUSH : (!idle && fcnt == FW'(1)) ? IDLE : state;
    fcnt_nx  = bad ? FW'(FLUSH_CYCLES) : idle ? fcnt : fcnt - FW'(1);
  end
  // one-cycle redirect pulse; the redirect address holds until the next mispredict
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      mispredict  <= 1'b0;
      redirect_PC <= '0;
    end else begin
      mispredict <= bad;
      if (bad) redirect_PC <= res_target;
    end
`ifdef RAS_VERIFY_STATS_EN
  // saturating tallies of judged resolves
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      stat_correct <= '0;
      stat_mispred <= '0;
    end else begin
      if (judge && ok && stat_correct != '1) stat_correct <= stat_correct + 32'd1;
      if (bad && stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
    end
`endif
endmodule

// File: tb/tb_ras_verify.sv
// tb_ras_verify: scoreboard bench for ras_verify
module tb_ras_verify;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          pred_valid = 1'b0, pred_hit = 1'b0;
  logic [AW-1:0] pred_pc = '0, pred_target = '0;
  logic          res_valid = 1'b0;
  logic [AW-1:0] res_pc = '0, res_target = '0;
  logic          mispredict, flush, pend_full;
  logic [AW-1:0] redirect_PC;
  logic [CW-1:0] pend_count;
  typedef struct {logic mis; logic [AW-1:0] rd;} exp_t;
  exp_t          exp_q[$];
  exp_t          e;
  logic [AW-1:0] model_rd = '0;
  int            checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  ras_verify #(.DEPTH(DEPTH), .ADDR_W(AW), .FLUSH_CYCLES(2)) dut (
    .CLK(CLK), .RESET(RESET),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_pc(pred_pc), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_target(res_target),
    .mispredict(mispredict), .redirect_PC(redirect_PC), .flush(flush),
    .pend_full(pend_full), .pend_count(pend_count)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_pred(input logic [AW-1:0] pc, input logic hit, input logic [AW-1:0] tgt);
    pred_valid = 1'b1; pred_hit = hit; pred_pc = pc; pred_target = tgt;
  endtask

  task automatic drive_res(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic mis);
    res_valid = 1'b1; res_pc = pc; res_target = tgt;
    if (mis) model_rd = tgt;
    exp_q.push_back('{mis, model_rd});
  endtask

  task automatic release_inputs;
    pred_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic hit, input logic [AW-1:0] tgt);
    drive_pred(pc, hit, tgt);
    tick;
    release_inputs;
  endtask

  task automatic resolve(input logic [AW-1:0] pc, input logic [AW-1:0] tgt, input logic mis);
    drive_res(pc, tgt, mis);
    tick;
    release_inputs;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (mispredict !== 1'b0 || flush !== 1'b0 || pend_count !== '0 || redirect_PC !== '0 || pend_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mis=%b flush=%b cnt=%0d rd=%h full=%b, expected all zero", mispredict, flush, pend_count, redirect_PC, pend_full);
    end
    RESET = 1'b1;
    tick;
  endtask

  task automatic test_correct;
    push(32'h400100, 1'b1, 32'h400208);
    checks++;
    if (pend_count !== CW'(1)) begin errors++; $display("FAIL correct_count_push: cnt=%0d expected 1", pend_count); end
    tick; tick;
    resolve(32'h400100, 32'h400208, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (mispredict !== e.mis || redirect_PC !== e.rd || flush !== 1'b0 || pend_count !== '0) begin
      errors++;
      $display("FAIL correct_resolve: mis=%b rd=%h flush=%b cnt=%0d expected mis=%b rd=%h flush=0 cnt=0", mispredict, redirect_PC, flush, pend_count, e.mis, e.rd);
    end
  endtask

  task automatic test_mispredict;
    push(32'h400100, 1'b1, 32'h400208);
    resolve(32'h400100, 32'h400300, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (mispredict !== e.mis || redirect_PC !== e.rd || flush !== 1'b1 || pend_count !== '0) begin
      errors++;
      $display("FAIL mispredict_pulse: mis=%b rd=%h flush=%b cnt=%0d expected mis=%b rd=%h flush=1 cnt=0", mispredict, redirect_PC, flush, pend_count, e.mis, e.rd);
    end
    tick;
    checks++;
    if (mispredict !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL mispredict_second_cycle: mis=%b flush=%b expected mis=0 flush=1", mispredict, flush); end
    tick;
    checks++;
    if (flush !== 1'b0 || redirect_PC !== model_rd) begin errors++; $display("FAIL mispredict_flush_end: flush=%b rd=%h expected flush=0 rd=%h", flush, redirect_PC, model_rd); end
  endtask

  task automatic test_empty_and_nohit;
    resolve(32'h400500, 32'h400600, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (mispredict !== e.mis || redirect_PC !== e.rd) begin errors++; $display("FAIL empty_resolve: mis=%b rd=%h expected mis=%b rd=%h", mispredict, redirect_PC, e.mis, e.rd); end
    tick; tick;
    push(32'h400700, 1'b0, 32'h400708);
    resolve(32'h400700, 32'h400708, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (mispredict !== e.mis || redirect_PC !== e.rd) begin errors++; $display("FAIL nohit_resolve: mis=%b rd=%h expected mis=%b rd=%h", mispredict, redirect_PC, e.mis, e.rd); end
    tick; tick;
  endtask

  task automatic test_full_wrap;
    for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(i*4), 1'b1, 32'h2000 + 32'(i*4));
    checks++;
    if (pend_count !== CW'(DEPTH) || pend_full !== 1'b1) begin errors++; $display("FAIL full_flag: cnt=%0d full=%b expected cnt=%0d full=1", pend_count, pend_full, DEPTH); end
    push(32'h9000, 1'b1, 32'h9008);
    checks++;
    if (pend_count !== CW'(DEPTH)) begin errors++; $display("FAIL full_drop: cnt=%0d expected %0d", pend_count, DEPTH); end
    drive_pred(32'h1010, 1'b1, 32'h2010);
    drive_res(32'h1000, 32'h2000, 1'b0);
    tick;
    release_inputs;
    e = exp_q.pop_front();
    checks++;
    if (mispredict !== e.mis || pend_count !== CW'(DEPTH)) begin errors++; $display("FAIL full_push_pop: mis=%b cnt=%0d expected mis=%b cnt=%0d", mispredict, pend_count, e.mis, DEPTH); end
    for (int i = 1; i <= DEPTH; i++) begin
      resolve(32'h1000 + 32'(i*4), 32'h2000 + 32'(i*4), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (mispredict !== e.mis || redirect_PC !== e.rd) begin errors++; $display("FAIL wrap_order_%0d: mis=%b rd=%h expected mis=%b rd=%h", i, mispredict, redirect_PC, e.mis, e.rd); end
    end
    checks++;
    if (pend_count !== '0 || flush !== 1'b0) begin errors++; $display("FAIL wrap_drain: cnt=%0d flush=%b expected 0 0", pend_count, flush); end
  endtask

  task automatic test_push_pop_empty;
    drive_pred(32'h3000, 1'b1, 32'h3008);
    drive_res(32'h3000, 32'h3008, 1'b1);
    tick;
    release_inputs;
    e = exp_q.pop_front();
    checks++;
    if (mispredict !== e.mis || redirect_PC !== e.rd || pend_count !== '0) begin
      errors++;
      $display("FAIL push_pop_empty: mis=%b rd=%h cnt=%0d expected mis=%b rd=%h cnt=0", mispredict, redirect_PC, pend_count, e.mis, e.rd);
    end
    tick; tick;
  endtask

  task automatic test_flush_ignore;
    resolve(32'h500, 32'h504, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (mispredict !== e.mis || flush !== 1'b1) begin errors++; $display("FAIL flush_enter: mis=%b flush=%b expected mis=%b flush=1", mispredict, flush, e.mis); end
    drive_pred(32'h600, 1'b1, 32'h608);
    res_valid = 1'b1; res_pc = 32'h700; res_target = 32'h7F0;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (mispredict !== 1'b0 || pend_count !== '0 || redirect_PC !== model_rd) begin
        errors++;
        $display("FAIL flush_ignore_%0d: mis=%b cnt=%0d rd=%h expected mis=0 cnt=0 rd=%h", i, mispredict, pend_count, redirect_PC, model_rd);
      end
    end
    release_inputs;
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL flush_ignore_exit: flush=%b expected 0", flush); end
  endtask

  task automatic test_reset_flush;
    int n;
    resolve(32'h800, 32'h900, 1'b1);
    e = exp_q.pop_front();
    #2;
    RESET = 1'b0;
    model_rd = '0;
    #1;
    checks++;
    if (flush !== 1'b0 || mispredict !== 1'b0 || pend_count !== '0 || redirect_PC !== '0) begin
      errors++;
      $display("FAIL reset_mid_flush: flush=%b mis=%b cnt=%0d rd=%h expected all zero", flush, mispredict, pend_count, redirect_PC);
    end
    @(negedge CLK);
    RESET = 1'b1;
    tick;
    n = 0;
    while (flush !== 1'b0 && n < 20) begin tick; n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL reset_idle_timeout: flush=%b expected 0 within 20 cycles", flush); end
    push(32'hA00, 1'b1, 32'hA08);
    resolve(32'hA00, 32'hA08, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (mispredict !== e.mis || redirect_PC !== e.rd || pend_count !== '0) begin
      errors++;
      $display("FAIL post_reset_resolve: mis=%b rd=%h cnt=%0d expected mis=%b rd=%h cnt=0", mispredict, redirect_PC, pend_count, e.mis, e.rd);
    end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_mispredict;
    test_empty_and_nohit;
    test_full_wrap;
    test_push_pop_empty;
    test_flush_ignore;
    test_reset_flush;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
